// File: rtl/mem_lsu_if.sv
// Word-wide data-memory bus between the load/store unit and memory.
// The LSU drives the request side and memory returns rdata together with a one-cycle ack.
interface mem_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: IDLE->REQ->DONE bus handshake, at least 3 cycles per op; StallM holds the pipeline until DONE.
// Misalignment trapping is enabled by MEM_LSU_MISALIGN_TRAP_EN; without it, misaligned addresses are rounded down and issued.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  DataWidthM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  mem_lsu_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_load;
  logic [1:0]  r_sz;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_misal;
  logic        r_buserr;

  logic        w_memop;
  logic        w_is_store;
  logic [1:0]  w_sz;
  logic        w_is_h;
  logic        w_is_w;
  logic        w_misal;
  logic [1:0]  w_off;
  logic        w_go;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_issue;
  logic        w_ack_ok;
  logic        w_tmo;
  logic        w_cnt_inc;
  logic        w_misal_pulse;

  // Widths 011/110/111 fall into the word case because only B and H are decoded explicitly.
  assign w_is_store = MemWriteM;
  assign w_memop    = MemWriteM | (ResultSrcM == 2'b01);
  assign w_sz       = DataWidthM[1:0];
  assign w_is_h     = (w_sz == SZ_H);
  assign w_is_w     = (w_sz != SZ_B) && (w_sz != SZ_H);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign w_misal = (w_is_h && ALUOutM[0]) || (w_is_w && (ALUOutM[1:0] != 2'b00));
  assign w_off   = ALUOutM[1:0];
`else
  assign w_misal = 1'b0;
  assign w_off   = w_is_w ? 2'b00 : (w_is_h ? {ALUOutM[1], 1'b0} : ALUOutM[1:0]);
`endif

  assign w_go = w_memop && !w_misal;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    if (w_sz == SZ_B) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{WriteDataM[7:0]}};
    end else if (w_sz == SZ_H) begin
      w_be    = 4'b0011 << {w_off[1], 1'b0};
      w_wdata = {2{WriteDataM[15:0]}};
    end
  end

  // Lane extraction uses the offset and width captured at issue time.
  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      2'd3:    w_byte = bus.mem_rdata[31:24];
      default: w_byte = bus.mem_rdata[7:0];
    endcase
    w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    w_ext  = bus.mem_rdata;
    if (r_sz == SZ_B) begin
      w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
    end else if (r_sz == SZ_H) begin
      w_ext = {{16{~r_uns & w_half[15]}}, w_half};
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    w_ack_ok      = 1'b0;
    w_tmo         = 1'b0;
    w_cnt_inc     = 1'b0;
    w_misal_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = S_REQ;
          w_issue     = 1'b1;
        end else if (w_memop && w_misal) begin
          w_misal_pulse = 1'b1;
        end
      end
      S_REQ: begin
        // An ack in the final counted cycle wins over the timeout.
        if (bus.mem_ack) begin
          w_state_nxt = S_DONE;
          w_ack_ok    = 1'b1;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_tmo       = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_load   <= 1'b0;
      r_sz     <= 2'b00;
      r_uns    <= 1'b0;
      r_off    <= 2'b00;
      r_cnt    <= 8'd0;
      r_rdata  <= 32'd0;
      r_misal  <= 1'b0;
      r_buserr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_misal  <= w_misal_pulse;
      r_buserr <= w_tmo;
      if (w_issue) begin
        r_req   <= 1'b1;
        r_we    <= w_is_store;
        r_addr  <= {ALUOutM[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_load  <= !w_is_store;
        r_sz    <= w_sz;
        r_uns   <= DataWidthM[2];
        r_off   <= w_off;
        r_cnt   <= 8'd0;
      end
      if (w_ack_ok || w_tmo) begin
        r_req <= 1'b0;
      end
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_ack_ok && r_load) begin
        r_rdata <= w_ext;
      end else if (w_tmo && r_load) begin
        r_rdata <= 32'd0;
      end
    end
  end

  // Gating with rst_n lets the stall drop together with the request while reset is held.
  assign StallM = rst_n & (((r_state == S_IDLE) & w_go) | (r_state == S_REQ));

  assign ReadDataM     = r_rdata;
  assign MisalignM     = r_misal;
  assign BusErrM       = r_buserr;
  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with TIMEOUT_CYCLES=4; memory responses are driven by hand.
// Misaligned-access expectations follow MEM_LSU_MISALIGN_TRAP_EN.
module tb_mem_lsu;
  logic        clk;
  logic        rst_n;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  DataWidthM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;

  int n_chk;
  int n_fail;

  int          t_stalls;
  int          t_reqs;
  logic [3:0]  t_be;
  logic [31:0] t_addr;
  logic        t_we;
  logic [31:0] t_wdata;

  mem_lsu_if bus ();

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .DataWidthM (DataWidthM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic we, input logic [1:0] rs, input logic [2:0] w,
                        input logic [31:0] a, input logic [31:0] wd);
    MemWriteM  = we;
    ResultSrcM = rs;
    DataWidthM = w;
    ALUOutM    = a;
    WriteDataM = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Op must already be applied; returns at the negedge of the DONE cycle.
  // wait_n < 0 never acks.
  task automatic txn(input int wait_n, input logic [31:0] rdata);
    int  c;
    bit  seen;
    bit  done;
    t_stalls = 0;
    t_reqs   = 0;
    seen     = 1'b0;
    done     = 1'b0;
    c        = 0;
    bus.mem_rdata = rdata;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (StallM) begin
        t_stalls++;
        seen = 1'b1;
      end
      if (bus.mem_req) begin
        t_reqs++;
        if (t_reqs == 1) begin
          t_be    = bus.mem_be;
          t_addr  = bus.mem_addr;
          t_we    = bus.mem_we;
          t_wdata = bus.mem_wdata;
        end
        bus.mem_ack = (wait_n >= 0) && (t_reqs == wait_n + 1);
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (seen && !StallM) done = 1'b1;
    end
    bus.mem_ack = 1'b0;
    chk("txn_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    set_op(1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    t_be = 4'd0; t_addr = 32'd0; t_we = 1'b0; t_wdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata",  ReadDataM, 32'd0);
    chk("rst_flags",  {28'd0, StallM, MisalignM, BusErrM, bus.mem_req}, 32'd0);
    chk("rst_addr",   bus.mem_addr, 32'd0);
    chk("rst_wdata",  bus.mem_wdata, 32'd0);
    chk("rst_be_we",  {27'd0, bus.mem_be, bus.mem_we}, 32'd0);
    tick();
    rst_n = 1'b1;

    // LW 0x100 with 3 wait cycles; the ack lands on the last counted cycle.
    tick();
    set_op(1'b0, 2'b01, 3'b010, 32'h100, 32'd0);
    txn(3, 32'hDEADBEEF);
    chk("lw_stalls", 32'(t_stalls), 32'd5);
    chk("lw_reqs",   32'(t_reqs), 32'd4);
    chk("lw_be",     {28'd0, t_be}, 32'hF);
    chk("lw_addr",   t_addr, 32'h100);
    chk("lw_we",     {31'd0, t_we}, 32'd0);
    chk("lw_rdata",  ReadDataM, 32'hDEADBEEF);
    chk("lw_noerr",  {30'd0, BusErrM, bus.mem_req}, 32'd0);

    tick();
    set_op(1'b0, 2'b01, 3'b000, 32'h103, 32'd0);
    txn(0, 32'h80112233);
    chk("lb_stalls", 32'(t_stalls), 32'd2);
    chk("lb_be",     {28'd0, t_be}, 32'h8);
    chk("lb_rdata",  ReadDataM, 32'hFFFFFF80);

    tick();
    set_op(1'b0, 2'b01, 3'b100, 32'h103, 32'd0);
    txn(0, 32'h80112233);
    chk("lbu_rdata", ReadDataM, 32'h00000080);

    tick();
    set_op(1'b1, 2'b00, 3'b001, 32'h0A, 32'h1234ABCD);
    txn(0, 32'hFFFFFFFF);
    chk("sh_addr",  t_addr, 32'h08);
    chk("sh_be",    {28'd0, t_be}, 32'hC);
    chk("sh_wdata", t_wdata, 32'hABCDABCD);
    chk("sh_we",    {31'd0, t_we}, 32'd1);
    chk("sh_keep",  ReadDataM, 32'h00000080);

    tick();
    set_op(1'b1, 2'b00, 3'b000, 32'h201, 32'h000000A5);
    txn(1, 32'd0);
    chk("sb_be",    {28'd0, t_be}, 32'h2);
    chk("sb_wdata", t_wdata, 32'hA5A5A5A5);
    chk("sb_addr",  t_addr, 32'h200);

    tick();
    set_op(1'b0, 2'b01, 3'b001, 32'h02, 32'd0);
    txn(0, 32'h80112233);
    chk("lh_be",    {28'd0, t_be}, 32'hC);
    chk("lh_rdata", ReadDataM, 32'hFFFF8011);

    tick();
    set_op(1'b0, 2'b01, 3'b101, 32'h00, 32'd0);
    txn(0, 32'h80118233);
    chk("lhu_rdata", ReadDataM, 32'h00008233);

    tick();
    set_op(1'b0, 2'b01, 3'b011, 32'h204, 32'd0);
    txn(0, 32'h13579BDF);
    chk("w011_be",    {28'd0, t_be}, 32'hF);
    chk("w011_rdata", ReadDataM, 32'h13579BDF);

    // MemWriteM wins when the load select is also set.
    tick();
    set_op(1'b1, 2'b01, 3'b010, 32'h208, 32'h0F0F0F0F);
    txn(0, 32'h77777777);
    chk("both_we",   {31'd0, t_we}, 32'd1);
    chk("both_keep", ReadDataM, 32'h13579BDF);

    // Idle cycles with a stray ack: nothing may change.
    tick();
    set_op(1'b0, 2'b00, 3'b010, 32'h300, 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("nop_stall", {30'd0, StallM, bus.mem_req}, 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("nop_keep", ReadDataM, 32'h13579BDF);

    tick();
    set_op(1'b0, 2'b01, 3'b010, 32'h102, 32'd0);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    chk("mis_stall", {30'd0, StallM, bus.mem_req}, 32'd0);
    tick();
    set_op(1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    chk("mis_pulse", {30'd0, MisalignM, bus.mem_req}, 32'h2);
    tick();
    @(negedge clk);
    chk("mis_clear", {30'd0, MisalignM, StallM}, 32'd0);
    chk("mis_keep",  ReadDataM, 32'h13579BDF);
`else
    txn(0, 32'hCAFEF00D);
    chk("mis_addr",  t_addr, 32'h100);
    chk("mis_be",    {28'd0, t_be}, 32'hF);
    chk("mis_rdata", ReadDataM, 32'hCAFEF00D);
    chk("mis_flag",  {31'd0, MisalignM}, 32'd0);
`endif

    // No ack: four request cycles, then a bus error and a zeroed load result.
    tick();
    set_op(1'b0, 2'b01, 3'b010, 32'h300, 32'd0);
    txn(-1, 32'h55555555);
    chk("tmo_reqs",   32'(t_reqs), 32'd4);
    chk("tmo_stalls", 32'(t_stalls), 32'd5);
    chk("tmo_err",    {30'd0, BusErrM, bus.mem_req}, 32'h2);
    chk("tmo_rdata",  ReadDataM, 32'd0);
    tick();
    set_op(1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    chk("tmo_pulse", {30'd0, BusErrM, StallM}, 32'd0);

    tick();
    set_op(1'b0, 2'b01, 3'b000, 32'h001, 32'd0);
    txn(0, 32'h0000C300);
    chk("lb1_rdata", ReadDataM, 32'hFFFFFFC3);

    // Asynchronous reset while a request is outstanding.
    tick();
    set_op(1'b0, 2'b01, 3'b010, 32'h400, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_drop", {30'd0, bus.mem_req, StallM}, 32'd0);
    set_op(1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_flags", {28'd0, StallM, MisalignM, BusErrM, bus.mem_req}, 32'd0);
    chk("arst_rdata", ReadDataM, 32'd0);
    chk("arst_addr",  bus.mem_addr, 32'd0);
    chk("arst_bewe",  {27'd0, bus.mem_be, bus.mem_we}, 32'd0);

    tick();
    set_op(1'b0, 2'b01, 3'b010, 32'h500, 32'd0);
    txn(0, 32'h2468ACE0);
    chk("post_stalls", 32'(t_stalls), 32'd2);
    chk("post_rdata",  ReadDataM, 32'h2468ACE0);

    tick();
    set_op(1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
